// File: rtl/reg_dst_pkg.sv
// reg_dst_pkg: destination-select encodings and default widths shared by the reg_dst_pipe slice.
package reg_dst_pkg;
    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam int DEFAULT_AW = 5;
    localparam int DEFAULT_LINK_REG = 31;
endpackage

// File: rtl/reg_dst_stage.sv
// reg_dst_stage: one {addr, we} pipeline slice; clear beats load, otherwise the slice holds.
module reg_dst_stage import reg_dst_pkg::*; #(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] addrIn,
    input  logic          weIn,
    output logic [AW-1:0] addr,
    output logic          we
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            we <= 1'b0;
        end else if (clear) begin
            addr <= '0;
            we <= 1'b0;
        end else if (load) begin
            addr <= addrIn;
            we <= weIn;
        end
    end
endmodule

// File: rtl/reg_dst_pipe.sv
// reg_dst_pipe: selects the write-destination register and carries it with its write-enable to writeback.
// Define REG_DST_FWD_EN to build the forwarding-match encoders; otherwise fwd_a/fwd_b are tied to 0.
module reg_dst_pipe import reg_dst_pkg::*; #(
    parameter int AW = DEFAULT_AW,
    parameter int DEPTH = 3,
    parameter int LINK_REG = DEFAULT_LINK_REG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       ins1,
    input  logic [AW-1:0]       ins2,
    input  logic [1:0]          mRegSel,
    input  logic                wr_en,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                flush,
    input  logic [AW-1:0]       src_a,
    input  logic [AW-1:0]       src_b,
    output logic [AW-1:0]       insAddress,
    output logic [DEPTH*AW-1:0] stage_addr,
    output logic [DEPTH-1:0]    stage_we,
    output logic [AW-1:0]       wb_addr,
    output logic                wb_we,
    output logic [DEPTH-1:0]    fwd_a,
    output logic [DEPTH-1:0]    fwd_b
);
    logic [DEPTH-1:0][AW-1:0] addrQ;
    logic [DEPTH-1:0][AW-1:0] addrIn;
    logic [DEPTH-1:0]         weQ;
    logic [DEPTH-1:0]         weIn;
    logic                     captureWe;

    assign insAddress = (mRegSel == SEL_RD) ? ins2 : (mRegSel == SEL_LINK) ? AW'(LINK_REG) : ins1;
    // r0 is hard-wired zero, so writes to it are never tracked for writeback or forwarding
    assign captureWe = wr_en & valid_in & (insAddress != '0);
    assign addrIn[0] = insAddress;
    assign weIn[0] = captureWe;

    for (genvar g = 1; g < DEPTH; g++) begin : gLink
        assign addrIn[g] = addrQ[g-1];
        assign weIn[g] = weQ[g-1];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        reg_dst_stage #(.AW(AW)) uStage (
            .clk(clk),
            .rst_n(rst_n),
            .load(!stall),
            .clear(g == 0 && flush),
            .addrIn(addrIn[g]),
            .weIn(weIn[g]),
            .addr(addrQ[g]),
            .we(weQ[g])
        );
    end

    assign stage_addr = addrQ;
    assign stage_we = weQ;
    assign wb_addr = addrQ[DEPTH-1];
    assign wb_we = weQ[DEPTH-1];

`ifdef REG_DST_FWD_EN
    // scan oldest to youngest so the youngest matching stage overwrites and wins
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (weQ[i] && addrQ[i] == src_a && src_a != '0) begin
                fwd_a = '0;
                fwd_a[i] = 1'b1;
            end
            if (weQ[i] && addrQ[i] == src_b && src_b != '0) begin
                fwd_b = '0;
                fwd_b[i] = 1'b1;
            end
        end
    end
`else
    logic unusedSrc;
    assign unusedSrc = ^{src_a, src_b};
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif
endmodule

// File: tb/tb_reg_dst_pipe.sv
// tb_reg_dst_pipe: directed stimulus with a writeback scoreboard plus direct stage/forwarding checks.
module tb_reg_dst_pipe;
    localparam int AW = 5;
    localparam int DEPTH = 3;
`ifdef REG_DST_FWD_EN
    localparam logic [DEPTH-1:0] FWD_MASK = '1;
`else
    localparam logic [DEPTH-1:0] FWD_MASK = '0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] ins1 = '0, ins2 = '0, src_a = '0, src_b = '0;
    logic [1:0] mRegSel = '0;
    logic wr_en = 1'b0, valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [AW-1:0] insAddress, wb_addr;
    logic [DEPTH*AW-1:0] stage_addr;
    logic [DEPTH-1:0] stage_we, fwd_a, fwd_b;
    logic wb_we;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] expQ[$];
    logic [AW-1:0] expHead;
    logic s0Pending = 1'b0;
    logic adv = 1'b0;
    int selExp[4] = '{3, 7, 31, 3};

    always #5 clk = ~clk;

    reg_dst_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .ins1(ins1), .ins2(ins2), .mRegSel(mRegSel),
        .wr_en(wr_en), .valid_in(valid_in), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .insAddress(insAddress), .stage_addr(stage_addr),
        .stage_we(stage_we), .wb_addr(wb_addr), .wb_we(wb_we), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // wb presents a new entry only after an edge that advanced the pipe
    always @(posedge clk) adv <= rst_n && !stall;

    always @(negedge clk) begin
        if (adv && wb_we) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got write to %0d, expected none", wb_addr);
            end else begin
                expHead = expQ.pop_front();
                if (wb_addr != expHead) begin
                    errors++;
                    $display("FAIL wb_addr: got %0d, expected %0d", wb_addr, expHead);
                end
            end
        end
    end

    task automatic cap(input logic [1:0] sel, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic we, input logic v, input logic [AW-1:0] expA, input logic expW);
        mRegSel = sel; ins1 = a1; ins2 = a2; wr_en = we; valid_in = v; stall = 1'b0; flush = 1'b0;
        s0Pending = expW;
        if (expW) expQ.push_back(expA);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cap(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // a would-be capture of r6 is presented throughout and must never be taken
    task automatic hold(input logic st, input logic fl, input int n);
        stall = st; flush = fl; wr_en = 1'b1; valid_in = 1'b1; mRegSel = 2'b00; ins1 = 5'd6;
        for (int k = 0; k < n; k++) begin
            if (fl && s0Pending) void'(expQ.pop_back());
            if (fl) s0Pending = 1'b0;
            @(posedge clk); #1;
        end
        stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stage_we", stage_we, 0);
        chk("reset_stage_addr", stage_addr, 0);
        chk("reset_wb_we", wb_we, 0);
        chk("reset_fwd_a", fwd_a, 0);
        chk("reset_fwd_b", fwd_b, 0);
        rst_n = 1'b1;

        ins1 = 5'd3; ins2 = 5'd7;
        for (int s = 0; s < 4; s++) begin
            mRegSel = 2'(s);
            #1;
            chk($sformatf("sel_%0d", s), insAddress, selExp[s]);
        end

        cap(2'b01, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1);
        chk("lat_stage0_addr", stage_addr[AW-1:0], 7);
        chk("lat_stage0_we", stage_we[0], 1);
        chk("lat_wb_we_c1", wb_we, 0);
        idle(1);
        chk("lat_wb_we_c2", wb_we, 0);
        idle(1);
        chk("lat_wb_we_c3", wb_we, 1);
        chk("lat_wb_addr_c3", wb_addr, 7);
        idle(1);
        chk("lat_wb_we_c4", wb_we, 0);

        cap(2'b00, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
        chk("r0_stage0_we", stage_we[0], 0);
        src_a = '0;
        #1;
        chk("r0_fwd_a", fwd_a, 0);
        cap(2'b00, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0);
        chk("invalid_stage0_we", stage_we[0], 0);

        cap(2'b00, 5'd4, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1);
        cap(2'b00, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1);
        hold(1'b1, 1'b0, 2);
        chk("stall_stage_addr", stage_addr, {5'd3, 5'd4, 5'd5});
        chk("stall_stage_we", stage_we, 3'b011);
        hold(1'b1, 1'b1, 1);
        chk("stallflush_stage_addr", stage_addr, {5'd3, 5'd4, 5'd0});
        chk("stallflush_stage_we", stage_we, 3'b010);
        hold(1'b0, 1'b1, 1);
        chk("flush_stage_addr", stage_addr, {5'd4, 5'd0, 5'd0});
        chk("flush_stage_we", stage_we, 3'b100);
        idle(3);

        src_a = 5'd9; src_b = 5'd4;
        cap(2'b00, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1);
        idle(1);
        cap(2'b00, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1);
        chk("fwd_stage_we", stage_we, 3'b101);
        chk("fwd_a_young", fwd_a, 3'b001 & FWD_MASK);
        chk("fwd_b_miss", fwd_b, 0);
        src_b = 5'd9;
        #1;
        chk("fwd_b_young", fwd_b, 3'b001 & FWD_MASK);
        hold(1'b1, 1'b1, 1);
        chk("fwd_a_old", fwd_a, 3'b100 & FWD_MASK);
        chk("fwd_b_old", fwd_b, 3'b100 & FWD_MASK);
        chk("fwd_clear_stage_addr", stage_addr, {5'd9, 5'd0, 5'd0});
        idle(3);

        cap(2'b01, 5'd0, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1);
        cap(2'b01, 5'd0, 5'd13, 1'b1, 1'b1, 5'd13, 1'b1);
        src_a = 5'd12;
        #1;
        chk("pre_reset_fwd_a", fwd_a, 3'b010 & FWD_MASK);
        rst_n = 1'b0;
        expQ.delete();
        s0Pending = 1'b0;
        #1;
        chk("async_reset_stage_we", stage_we, 0);
        chk("async_reset_stage_addr", stage_addr, 0);
        chk("async_reset_wb_we", wb_we, 0);
        chk("async_reset_fwd_a", fwd_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        hold(1'b1, 1'b0, 1);
        chk("post_reset_stall_we", stage_we, 0);
        cap(2'b01, 5'd0, 5'd14, 1'b1, 1'b1, 5'd14, 1'b1);
        idle(3);
        chk("scoreboard_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
